// File: rtl/csa64_eqg.sv
// csa64_eqg: registered 64-bit unsigned carry-select adder with equal GROUP_W-bit groups.
// Define CSA64_EQG_INREG_EN to add the operand register stage (latency 2 instead of 1).
module csa64_eqg #(
  parameter int GROUP_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic [63:0] sum,
  output logic        crout
);
  localparam int NG = 64 / GROUP_W;
  if (64 % GROUP_W != 0 || GROUP_W < 4 || GROUP_W > 32) begin : bad_w
    $error("csa64_eqg: GROUP_W must be 4, 8, 16 or 32");
  end
  logic [63:0] a, b, s_d;
  logic [NG:0] c;
`ifdef CSA64_EQG_INREG_EN
  logic [63:0] a_q, b_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= op1;
      b_q <= op2;
    end
  assign a = a_q;
  assign b = b_q;
`else
  assign a = op1;
  assign b = op2;
`endif
  assign c[0] = 1'b0;
  for (genvar g = 0; g < NG; g++) begin : grp
    localparam int L = g * GROUP_W;
    logic [GROUP_W:0] r0;
    assign r0 = {1'b0, a[L+:GROUP_W]} + {1'b0, b[L+:GROUP_W]};
    if (g == 0) begin : rip
      assign {c[1], s_d[L+:GROUP_W]} = r0;
    end else begin : sel
      // carry-in-1 twin; the incoming group carry only drives the mux select
      logic [GROUP_W:0] r1;
      assign r1 = {1'b0, a[L+:GROUP_W]} + {1'b0, b[L+:GROUP_W]} + (GROUP_W+1)'(1);
      assign {c[g+1], s_d[L+:GROUP_W]} = c[g] ? r1 : r0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sum   <= '0;
      crout <= 1'b0;
    end else begin
      sum   <= s_d;
      crout <= c[NG];
    end
endmodule

// File: tb/tb_csa64_eqg.sv
// tb_csa64_eqg: checks four GROUP_W variants of csa64_eqg against a 65-bit reference add.
module tb_csa64_eqg;
`ifdef CSA64_EQG_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] op1 = '0, op2 = '0;
  logic [63:0] sum_w [4];
  logic        crout_w [4];
  logic [64:0] hist [$];
  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;

  csa64_eqg #(.GROUP_W(4))  u4  (.clock(clock), .reset(reset), .op1(op1), .op2(op2), .sum(sum_w[0]), .crout(crout_w[0]));
  csa64_eqg #(.GROUP_W(8))  u8  (.clock(clock), .reset(reset), .op1(op1), .op2(op2), .sum(sum_w[1]), .crout(crout_w[1]));
  csa64_eqg #(.GROUP_W(16)) u16 (.clock(clock), .reset(reset), .op1(op1), .op2(op2), .sum(sum_w[2]), .crout(crout_w[2]));
  csa64_eqg #(.GROUP_W(32)) u32 (.clock(clock), .reset(reset), .op1(op1), .op2(op2), .sum(sum_w[3]), .crout(crout_w[3]));

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [64:0] expected();
    return hist.size() >= LAT ? hist[hist.size()-LAT] : 65'd0;
  endfunction

  task automatic chk_all(input string tag, input logic [64:0] exp);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s/w%0d", tag, 4 << i), {crout_w[i], sum_w[i]}, exp);
  endtask

  // called at a negedge: present operands, take one rising edge, compare at the next negedge
  task automatic cycle(input string tag, input logic [63:0] a, input logic [63:0] b);
    op1 = a;
    op2 = b;
    @(posedge clock);
    hist.push_back({1'b0, a} + {1'b0, b});
    @(negedge clock);
    chk_all(tag, expected());
  endtask

  // called at a negedge: asynchronous assert, hold across an edge, release at a negedge
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1 chk_all({tag, "_async"}, 65'd0);
    @(posedge clock);
    #1 chk_all({tag, "_held"}, 65'd0);
    @(negedge clock);
    reset = 1'b1;
    hist.delete();
  endtask

  initial begin
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_all("rst_low", 65'd0);
    @(posedge clock);
    #1 chk_all("rst_low_clk", 65'd0);
    @(negedge clock);
    reset = 1'b1;
    cycle("rel0", 64'd0, 64'd0);
    cycle("rel1", 64'd0, 64'd0);
    cycle("vec1", 64'h1234_FFFF_DFFF_EEEE, 64'hDDDD_DDDD_DDDD_DDDD);
    cycle("vec2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    cycle("vec3", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle("b2b1", 64'h00FF, 64'h1);
    cycle("b2b2", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    for (int i = 0; i < LAT; i++) cycle("drain", 64'd0, 64'd0);
    chk_all("vec_spot", 65'd0);
    cycle("p1", 64'h00FF, 64'h1);
    pulse_reset("mid");
    cycle("post1", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    cycle("post2", 64'h1234_FFFF_DFFF_EEEE, 64'hDDDD_DDDD_DDDD_DDDD);
    cycle("post3", 64'd0, 64'd0);
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(7))
        0: b = ~a;
        1: b = ~a + 64'd1;
        2: a = '1;
        default: ;
      endcase
      cycle("rand", a, b);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
